fwd_hazard_unit: RTL and testbench

Parametrised forwarding and hazard controller for the pipelined RISC-V core. It tracks destination registers of in-flight instructions in an internal shift register of NUM_STAGES entries. Position 1 is EX, position 2 is MEM, and so on. From that state it produces registered per-operand bypass selects for the EX stage, a combinational load-use stall, and a stall counter. It sits beside the decode stage and drives the EX operand muxes.

---
 rtl/fwd_hazard_unit_if.sv | 30 +++
 rtl/fwd_hazard_unit.sv | 94 +++++++++
 tb/tb_fwd_hazard_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_if.sv
// Decode-side request and EX bypass/stall response bundle for the forwarding/hazard unit.
interface fwd_hazard_unit_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned CNT_WIDTH  = 16
);
  localparam int unsigned SEL_W = $clog2(NUM_STAGES + 1);

  logic                  id_valid;
  logic [ADDR_WIDTH-1:0] id_rs1;
  logic [ADDR_WIDTH-1:0] id_rs2;
  logic [ADDR_WIDTH-1:0] id_rd;
  logic                  id_we;
  logic                  id_is_load;
  logic                  flush;
  logic [SEL_W-1:0]      ex_op1_sel;
  logic [SEL_W-1:0]      ex_op2_sel;
  logic                  stall;
  logic [CNT_WIDTH-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_we, id_is_load, flush,
    input  ex_op1_sel, ex_op2_sel, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_we, id_is_load, flush,
    output ex_op1_sel, ex_op2_sel, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Tracks in-flight destination registers and produces EX bypass selects,
// a combinational load-use/RAW stall and a saturating stall counter.
module fwd_hazard_unit #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fwd_hazard_unit_if.slave   bus
);

  localparam int unsigned SEL_W = $clog2(NUM_STAGES + 1);

  typedef struct packed {
    logic                  v;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  ld;
  } entry_t;

  // Index 0 is position 1 (EX), index 1 is position 2 (MEM), ...
  entry_t                pipe_q [NUM_STAGES];
  logic [NUM_STAGES-1:0] hit1;
  logic [NUM_STAGES-1:0] hit2;
  logic [SEL_W-1:0]      sel1_c;
  logic [SEL_W-1:0]      sel2_c;
  logic [SEL_W-1:0]      sel1_q;
  logic [SEL_W-1:0]      sel2_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  load_use;
  logic                  raw;
  logic                  stall_c;

  // Match each operand against every tracked producer
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int j = 0; j < int'(NUM_STAGES); j++) begin
      hit1[j] = pipe_q[j].v && (pipe_q[j].rd == bus.id_rs1);
      hit2[j] = pipe_q[j].v && (pipe_q[j].rd == bus.id_rs2);
    end
  end

  // Youngest producer wins: scan oldest to youngest so the smallest position overrides
  always_comb begin
    sel1_c = '0;
    sel2_c = '0;
    if (FWD_EN != 0) begin
      for (int j = int'(NUM_STAGES) - 1; j >= 0; j--) begin
        if (hit1[j]) sel1_c = SEL_W'(j + 1);
        if (hit2[j]) sel2_c = SEL_W'(j + 1);
      end
    end
  end

  always_comb begin
    load_use = pipe_q[0].ld && (hit1[0] || hit2[0]);
    raw      = |{hit1, hit2};
    stall_c  = bus.id_valid && !bus.flush && ((FWD_EN != 0) ? load_use : raw);
  end

  // Producer shift register, bypass selects and stall counter; flush beats stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < int'(NUM_STAGES); j++) pipe_q[j] <= '0;
      sel1_q <= '0;
      sel2_q <= '0;
      cnt_q  <= '0;
    end else if (bus.flush) begin
      for (int j = 0; j < int'(NUM_STAGES); j++) pipe_q[j] <= '0;
      sel1_q <= '0;
      sel2_q <= '0;
    end else begin
      for (int j = int'(NUM_STAGES) - 1; j > 0; j--) pipe_q[j] <= pipe_q[j-1];
      if (stall_c) begin
        pipe_q[0] <= '0;
        sel1_q    <= '0;
        sel2_q    <= '0;
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
      end else begin
        pipe_q[0] <= {bus.id_valid & bus.id_we & (bus.id_rd != '0), bus.id_rd, bus.id_is_load};
        sel1_q    <= bus.id_valid ? sel1_c : '0;
        sel2_q    <= bus.id_valid ? sel2_c : '0;
      end
    end
  end

  assign bus.ex_op1_sel = sel1_q;
  assign bus.ex_op2_sel = sel2_q;
  assign bus.stall      = stall_c;
  assign bus.stall_cnt  = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: a forwarding instance and an interlock-only instance with a narrow counter.
module tb_fwd_hazard_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.ADDR_WIDTH(5), .NUM_STAGES(2), .CNT_WIDTH(16)) bus_f ();
  fwd_hazard_unit_if #(.ADDR_WIDTH(5), .NUM_STAGES(2), .CNT_WIDTH(3))  bus_i ();

  fwd_hazard_unit #(.ADDR_WIDTH(5), .NUM_STAGES(2), .FWD_EN(1), .CNT_WIDTH(16)) u_fwd (
    .clk(clk), .rst_n(rst_n), .bus(bus_f)
  );
  fwd_hazard_unit #(.ADDR_WIDTH(5), .NUM_STAGES(2), .FWD_EN(0), .CNT_WIDTH(3)) u_ilk (
    .clk(clk), .rst_n(rst_n), .bus(bus_i)
  );

  typedef struct packed {
    logic        stall;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [15:0] cnt;
  } exp_t;

  // ctl = {valid, we, is_load, flush}
  localparam logic [3:0] NOP = 4'b0000;
  localparam logic [3:0] ALU = 4'b1100;
  localparam logic [3:0] USE = 4'b1000;
  localparam logic [3:0] LD  = 4'b1110;
  localparam logic [3:0] FL  = 4'b0001;

  exp_t  q_f [$];
  exp_t  q_i [$];
  string n_f [$];
  string n_i [$];
  int    checks = 0;
  int    errors = 0;

  task automatic idle_f();
    bus_f.id_valid = 1'b0; bus_f.id_rs1 = '0; bus_f.id_rs2 = '0; bus_f.id_rd = '0;
    bus_f.id_we = 1'b0; bus_f.id_is_load = 1'b0; bus_f.flush = 1'b0;
  endtask

  task automatic idle_i();
    bus_i.id_valid = 1'b0; bus_i.id_rs1 = '0; bus_i.id_rs2 = '0; bus_i.id_rd = '0;
    bus_i.id_we = 1'b0; bus_i.id_is_load = 1'b0; bus_i.flush = 1'b0;
  endtask

  task automatic step_f(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [3:0] ctl, input logic e_st, input logic [1:0] e1,
                        input logic [1:0] e2, input logic [15:0] ec, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    idle_i();
    bus_f.id_valid = ctl[3]; bus_f.id_we = ctl[2]; bus_f.id_is_load = ctl[1]; bus_f.flush = ctl[0];
    bus_f.id_rs1 = rs1; bus_f.id_rs2 = rs2; bus_f.id_rd = rd;
    e = {e_st, e1, e2, ec};
    q_f.push_back(e);
    n_f.push_back(nm);
  endtask

  task automatic step_i(input logic [4:0] rs1, input logic [4:0] rd, input logic [3:0] ctl,
                        input logic e_st, input logic [15:0] ec, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    idle_f();
    bus_i.id_valid = ctl[3]; bus_i.id_we = ctl[2]; bus_i.id_is_load = ctl[1]; bus_i.flush = ctl[0];
    bus_i.id_rs1 = rs1; bus_i.id_rs2 = 5'd0; bus_i.id_rd = rd;
    e = {e_st, 2'd0, 2'd0, ec};
    q_i.push_back(e);
    n_i.push_back(nm);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle_f();
    idle_i();
    q_f.push_back('0); n_f.push_back("reset_f");
    q_i.push_back('0); n_i.push_back("reset_i");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  exp_t  mf_e, mf_g, mi_e, mi_g;
  string mf_n, mi_n;

  // Monitors: compare whatever is outstanding against the outputs each cycle
  always @(negedge clk) begin
    if (q_f.size() > 0) begin
      mf_e = q_f.pop_front();
      mf_n = n_f.pop_front();
      mf_g = {bus_f.stall, bus_f.ex_op1_sel, bus_f.ex_op2_sel, bus_f.stall_cnt};
      checks++;
      if (mf_g !== mf_e) begin
        errors++;
        $display("FAIL %s: got stall=%0d sel1=%0d sel2=%0d cnt=%0d, want stall=%0d sel1=%0d sel2=%0d cnt=%0d",
                 mf_n, mf_g.stall, mf_g.s1, mf_g.s2, mf_g.cnt, mf_e.stall, mf_e.s1, mf_e.s2, mf_e.cnt);
      end
    end
  end

  always @(negedge clk) begin
    if (q_i.size() > 0) begin
      mi_e = q_i.pop_front();
      mi_n = n_i.pop_front();
      mi_g = {bus_i.stall, bus_i.ex_op1_sel, bus_i.ex_op2_sel, 16'(bus_i.stall_cnt)};
      checks++;
      if (mi_g !== mi_e) begin
        errors++;
        $display("FAIL %s: got stall=%0d sel1=%0d sel2=%0d cnt=%0d, want stall=%0d sel1=%0d sel2=%0d cnt=%0d",
                 mi_n, mi_g.stall, mi_g.s1, mi_g.s2, mi_g.cnt, mi_e.stall, mi_e.s1, mi_e.s2, mi_e.cnt);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int m;
    logic st;
    idle_f();
    idle_i();

    // Back-to-back ALU RAW, then both operands on one producer
    do_reset();
    step_f(5'd1, 5'd2, 5'd5, ALU, 1'b0, 2'd0, 2'd0, 16'd0, "raw_prod");
    step_f(5'd5, 5'd6, 5'd8, USE, 1'b0, 2'd0, 2'd0, 16'd0, "raw_cons");
    step_f(5'd5, 5'd5, 5'd0, USE, 1'b0, 2'd1, 2'd0, 16'd0, "raw_sel1");
    step_f(5'd0, 5'd0, 5'd0, NOP, 1'b0, 2'd2, 2'd2, 16'd0, "same_rd_both");

    // Nearest producer wins
    do_reset();
    step_f(5'd0, 5'd0, 5'd7, ALU, 1'b0, 2'd0, 2'd0, 16'd0, "near_p1");
    step_f(5'd0, 5'd0, 5'd7, ALU, 1'b0, 2'd0, 2'd0, 16'd0, "near_p2");
    step_f(5'd7, 5'd0, 5'd0, USE, 1'b0, 2'd0, 2'd0, 16'd0, "near_cons");
    step_f(5'd0, 5'd0, 5'd0, NOP, 1'b0, 2'd1, 2'd0, 16'd0, "near_sel");

    // Distance 2
    do_reset();
    step_f(5'd0, 5'd0, 5'd7, ALU, 1'b0, 2'd0, 2'd0, 16'd0, "d2_prod");
    step_f(5'd0, 5'd0, 5'd0, NOP, 1'b0, 2'd0, 2'd0, 16'd0, "d2_nop");
    step_f(5'd7, 5'd0, 5'd0, USE, 1'b0, 2'd0, 2'd0, 16'd0, "d2_cons");
    step_f(5'd0, 5'd0, 5'd0, NOP, 1'b0, 2'd2, 2'd0, 16'd0, "d2_sel");

    // Distance 3 falls off the end
    do_reset();
    step_f(5'd0, 5'd0, 5'd7, ALU, 1'b0, 2'd0, 2'd0, 16'd0, "d3_prod");
    step_f(5'd0, 5'd0, 5'd0, NOP, 1'b0, 2'd0, 2'd0, 16'd0, "d3_nop1");
    step_f(5'd0, 5'd0, 5'd0, NOP, 1'b0, 2'd0, 2'd0, 16'd0, "d3_nop2");
    step_f(5'd7, 5'd0, 5'd0, USE, 1'b0, 2'd0, 2'd0, 16'd0, "d3_cons");
    step_f(5'd0, 5'd0, 5'd0, NOP, 1'b0, 2'd0, 2'd0, 16'd0, "d3_sel");

    // Load-use: one stall cycle then forward from position 2
    do_reset();
    step_f(5'd0, 5'd0, 5'd3, LD,  1'b0, 2'd0, 2'd0, 16'd0, "lu_load");
    step_f(5'd0, 5'd3, 5'd9, ALU, 1'b1, 2'd0, 2'd0, 16'd0, "lu_stall");
    step_f(5'd0, 5'd3, 5'd9, ALU, 1'b0, 2'd0, 2'd0, 16'd1, "lu_release");
    step_f(5'd0, 5'd0, 5'd0, NOP, 1'b0, 2'd0, 2'd2, 16'd1, "lu_sel2");

    // x0 and we=0 never create hazards
    do_reset();
    step_f(5'd0, 5'd0, 5'd0, ALU, 1'b0, 2'd0, 2'd0, 16'd0, "x0_prod");
    step_f(5'd0, 5'd0, 5'd4, USE, 1'b0, 2'd0, 2'd0, 16'd0, "we0_prod");
    step_f(5'd0, 5'd4, 5'd0, USE, 1'b0, 2'd0, 2'd0, 16'd0, "x0_we0_cons");
    step_f(5'd0, 5'd0, 5'd0, LD,  1'b0, 2'd0, 2'd0, 16'd0, "x0_load");
    step_f(5'd0, 5'd0, 5'd0, USE, 1'b0, 2'd0, 2'd0, 16'd0, "x0_load_use");
    step_f(5'd0, 5'd0, 5'd0, NOP, 1'b0, 2'd0, 2'd0, 16'd0, "x0_sel");

    // Flush beats stall and kills tracked producers
    do_reset();
    step_f(5'd0, 5'd0, 5'd3, LD,       1'b0, 2'd0, 2'd0, 16'd0, "fl_load");
    step_f(5'd3, 5'd0, 5'd0, USE | FL, 1'b0, 2'd0, 2'd0, 16'd0, "fl_over_stall");
    step_f(5'd3, 5'd0, 5'd0, USE,      1'b0, 2'd0, 2'd0, 16'd0, "fl_cleared");
    step_f(5'd0, 5'd0, 5'd5, ALU,      1'b0, 2'd0, 2'd0, 16'd0, "fl_prod");
    step_f(5'd5, 5'd0, 5'd0, USE | FL, 1'b0, 2'd0, 2'd0, 16'd0, "fl_cons");
    step_f(5'd0, 5'd0, 5'd0, NOP,      1'b0, 2'd0, 2'd0, 16'd0, "fl_sel0");

    // Reset asserted while a stall is active
    do_reset();
    step_f(5'd0, 5'd0, 5'd3, LD,  1'b0, 2'd0, 2'd0, 16'd0, "rs_load");
    step_f(5'd0, 5'd3, 5'd3, LD,  1'b1, 2'd0, 2'd0, 16'd0, "rs_stall1");
    step_f(5'd0, 5'd3, 5'd3, LD,  1'b0, 2'd0, 2'd0, 16'd1, "rs_load2");
    step_f(5'd3, 5'd0, 5'd0, USE, 1'b1, 2'd0, 2'd2, 16'd1, "rs_stall2");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    step_f(5'd3, 5'd0, 5'd0, USE, 1'b0, 2'd0, 2'd0, 16'd0, "rst_mid_stall");
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Interlock-only: RAW holds for the full tracked depth, counter saturates at 7
    do_reset();
    step_i(5'd0, 5'd4, ALU, 1'b0, 16'd0, "ilk_prod");
    step_i(5'd4, 5'd4, ALU, 1'b1, 16'd0, "ilk_stall1");
    step_i(5'd4, 5'd4, ALU, 1'b1, 16'd1, "ilk_stall2");
    m = 2;
    for (int i = 0; i < 12; i++) begin
      st = (i % 3) != 0;
      step_i(5'd4, 5'd4, ALU, st, 16'(m), "ilk_sat");
      if (st && m < 7) m++;
    end
    step_i(5'd0, 5'd0, NOP, 1'b0, 16'd7, "ilk_saturated");

    repeat (2) @(posedge clk);
    checks++;
    if (q_f.size() + q_i.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding, want 0", q_f.size() + q_i.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
